vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised VGA raster timing generator that supersedes the fixed 800x600 generator. It produces horizontal and vertical sync with programmable polarity, data-enable and blank, pixel coordinates, line and frame strobes, and a look-ahead pixel request for the framebuffer read path. A frame-aligned enable replaces the old mid-line hold, so timing never breaks inside a frame. It sits between the pixel clock domain root and the pixel FIFO/DAC output stage.

## Interface
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (clocks)
- H_SYNC, 128, horizontal sync width
- H_BP, 88, horizontal back porch
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width
- V_BP, 23, vertical back porch
- HS_POL, 1, active level of hs
- VS_POL, 1, active level of vs
- PREFETCH, 2, cycles by which req leads de; 1 ≤ PREFETCH < H_FP+H_SYNC+H_BP
- CW, 11, counter/coordinate width; 2^CW > H_TOTAL and 2^CW > V_TOTAL

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  run request, honoured at frame boundaries
- hs  out  1  horizontal sync, registered
- vs  out  1  vertical sync, registered
- de  out  1  data enable (visible pixel), registered
- blank  out  1  ~de
- x  out  CW  pixel column valid while de, else 0
- y  out  CW  pixel row valid while de, else 0
- line_start  out  1  one-cycle pulse with the first de of each line
- frame_start  out  1  one-cycle pulse with the first de of each frame
- req  out  1  high exactly PREFETCH cycles before each de cycle
- running  out  1  high in RUN or STOP

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is formed the same way from the vertical parameters. Order in each axis: active, front porch, sync, back porch.
- hc counts 0..H_TOTAL-1. vc advances when hc = H_TOTAL-1 and wraps from V_TOTAL-1 to 0.
- Decodes:
  - de_n = hc<H_ACTIVE && vc<V_ACTIVE
  - hs_n active for H_ACTIVE+H_FP ≤ hc < H_ACTIVE+H_FP+H_SYNC; vs_n is the vertical equivalent
  - hs/vs output level = HS_POL/VS_POL when active, else the inverse
- FSM states:
  - IDLE: counters held at 0. Outputs inactive (hs/vs at inactive level, de=0, blank=1, x=y=0).
  - RUN: counters advance every cycle.
  - STOP: counters advance and the current frame completes.
- FSM transitions:
  - IDLE→RUN when enable=1. Counters start at (0,0) on the next cycle.
  - RUN→STOP when enable=0.
  - STOP→RUN when enable=1 before the frame wrap, with no gap.
  - STOP→IDLE at the frame wrap (hc=H_TOTAL-1, vc=V_TOTAL-1).
  - RUN at the frame wrap stays in RUN.
- req is decoded from a look-ahead position hc+PREFETCH. If that value is ≥ H_TOTAL, it wraps to the next line (vc+1, modulo V_TOTAL).
  - At the frame wrap, req for row 0 is raised only if the state will be RUN, i.e. RUN with enable=1, or STOP with enable=1.
- reset low: state=IDLE and all outputs take their IDLE values immediately.

## Timing
- All outputs are registered with one cycle of latency from the counter position. hs, vs and de stay mutually aligned.
- From IDLE, enable sampled high on cycle t: the counter is (0,0) at t+1, and de=1, frame_start=1, line_start=1 at t+2.
- req at cycle t guarantees de at t+PREFETCH, including across line and frame wraps. The matching x is the column presented with that de.
- Dropping enable mid-frame never truncates a line or frame. Enable toggles shorter than a frame are tolerated.
- Arithmetic is unsigned CW-bit. Parameter illegality (PREFETCH or width constraints) is caught by elaboration-time checks.

## Structure
- Package vga_timing_pkg holds:
  - the state enum (IDLE, RUN, STOP)
  - mode constant sets: 800x600@60 (40/128/88, 1/4/23) and 800x600@72 (56/120/64, 37/6/23)
  - a function returning H_TOTAL/V_TOTAL
- Sub-module vga_axis_counter is instanced twice (horizontal and vertical). Each instance has parameters ACTIVE/FP/SYNC/BP, inputs inc/clr, and outputs count, active, sync and wrap.

## Test plan
- Default params, enable held 1 → period of 1056 clocks per line; hs high for clocks 841–968 after line start; 628 lines per frame; vs high on lines 601–604.
- @72 constants with HS_POL=VS_POL=0 → 1040×666 totals and low-true sync pulses of 120 clocks and 6 lines.
- PREFETCH=3 → every rising de is preceded by req exactly 3 cycles earlier, including pixel (0,0) after a frame wrap; req count equals de count per frame (480000).
- enable dropped at line 300 → frame completes to vc=627, then IDLE with blank=1 and running=0. Re-asserting enable at line 500 instead gives a seamless next frame_start.
- reset pulsed low mid-active → all outputs take IDLE values asynchronously. After release with enable=1, the first frame_start arrives 2 cycles after the first enable sample.
- x/y check → x counts 0..799 on each de run, y counts 0..599; x=y=0 whenever de=0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA raster timing generator: FSM state encoding,
// standard mode constant sets and the per-axis total helper.
package vga_timing_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t STOP = 2'd2;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } axis_t;

    typedef struct packed {
        axis_t h;
        axis_t v;
    } mode_t;

    localparam mode_t MODE_800X600_60 = '{h: '{800, 40, 128, 88}, v: '{600, 1, 4, 23}};
    localparam mode_t MODE_800X600_72 = '{h: '{800, 56, 120, 64}, v: '{600, 37, 6, 23}};

    // Total period of one axis in clocks (horizontal) or lines (vertical).
    function automatic int unsigned axis_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis: wrapping position counter with active, sync and wrap decodes.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = 800,
    parameter int unsigned FP     = 40,
    parameter int unsigned SYNC   = 128,
    parameter int unsigned BP     = 88,
    parameter int unsigned CW     = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          active,
    output logic          sync,
    output logic          wrap
);

    localparam int unsigned   TOTAL    = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
    localparam logic [CW-1:0] ACT_END  = CW'(ACTIVE);
    localparam logic [CW-1:0] SYNC_LO  = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] SYNC_HI  = CW'(ACTIVE + FP + SYNC);
    localparam logic [CW-1:0] ONE      = CW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + ONE;
        end
    end

    assign wrap   = (count == LAST);
    assign active = (count < ACT_END);
    assign sync   = (count >= SYNC_LO) && (count < SYNC_HI);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with frame-aligned enable, registered
// sync/de/coordinates, line/frame strobes and a look-ahead pixel request.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BP     = 88,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BP     = 23,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1,
    parameter int unsigned PREFETCH = 2,
    parameter int unsigned CW       = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic          blank,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          req,
    output logic          running
);

    localparam int unsigned H_TOTAL    = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL    = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [CW:0] H_TOTAL_W  = (CW+1)'(H_TOTAL);
    localparam logic [CW:0] H_ACTIVE_W = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0] V_ACTIVE_W = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0] PREFETCH_W = (CW+1)'(PREFETCH);
    localparam logic [CW:0] ONE_W      = (CW+1)'(1);

    if (PREFETCH < 1 || PREFETCH >= H_FP + H_SYNC + H_BP) begin : g_bad_prefetch
        $error("vga_timing_gen: PREFETCH must satisfy 1 <= PREFETCH < H_FP+H_SYNC+H_BP");
    end
    if (64'(H_TOTAL) >= (64'd1 << CW) || 64'(V_TOTAL) >= (64'd1 << CW)) begin : g_bad_width
        $error("vga_timing_gen: CW too small for H_TOTAL or V_TOTAL");
    end

    state_t        state, state_next;
    logic [CW-1:0] hc, vc;
    logic          h_active, h_sync, h_wrap;
    logic          v_active, v_sync, v_wrap;
    logic          frame_wrap, de_n, req_n;
    logic          h_ahead_wrap;
    logic [CW:0]   h_ahead, h_ahead_col, v_ahead_row;

    assign running    = (state != IDLE);
    assign frame_wrap = h_wrap && v_wrap;
    assign de_n       = h_active && v_active;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CW     (CW)
    ) u_h_counter (
        .clk    (clk),
        .reset  (reset),
        .inc    (running),
        .clr    (!running),
        .count  (hc),
        .active (h_active),
        .sync   (h_sync),
        .wrap   (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CW     (CW)
    ) u_v_counter (
        .clk    (clk),
        .reset  (reset),
        .inc    (running && h_wrap),
        .clr    (!running),
        .count  (vc),
        .active (v_active),
        .sync   (v_sync),
        .wrap   (v_wrap)
    );

    // A drop of enable seen on the last cycle of a frame ends the run at that wrap.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (enable) state_next = RUN;
            RUN:  if (!enable) state_next = frame_wrap ? IDLE : STOP;
            STOP: begin
                if (enable) begin
                    state_next = RUN;
                end else if (frame_wrap) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Look-ahead position; row 0 of the next frame only counts if the run continues.
    always_comb begin
        h_ahead      = {1'b0, hc} + PREFETCH_W;
        h_ahead_wrap = (h_ahead >= H_TOTAL_W);
        h_ahead_col  = h_ahead_wrap ? h_ahead - H_TOTAL_W : h_ahead;
        if (!h_ahead_wrap) begin
            v_ahead_row = {1'b0, vc};
        end else if (v_wrap) begin
            v_ahead_row = '0;
        end else begin
            v_ahead_row = {1'b0, vc} + ONE_W;
        end
        req_n = running && (h_ahead_col < H_ACTIVE_W) && (v_ahead_row < V_ACTIVE_W) &&
                (enable || !(h_ahead_wrap && v_wrap));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            req         <= 1'b0;
        end else begin
            state       <= state_next;
            hs          <= (running && h_sync) ? HS_POL : ~HS_POL;
            vs          <= (running && v_sync) ? VS_POL : ~VS_POL;
            de          <= running && de_n;
            x           <= (running && de_n) ? hc : '0;
            y           <= (running && de_n) ? vc : '0;
            line_start  <= running && de_n && (hc == '0);
            frame_start <= running && de_n && (hc == '0) && (vc == '0);
            req         <= req_n;
        end
    end

    assign blank = ~de;

endmodule
